// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-TX-side signals of the shared transmitter arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_par_en;
  logic [NUM_REQ-1:0] req_par_typ;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic PAR_EN;
  logic PAR_TYP;
  logic DATA_VALID;
  logic Busy;
  modport master (
    input req, req_data, req_par_en, req_par_typ, Busy,
    output gnt, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
  );
  modport slave (
    output req, req_data, req_par_en, req_par_typ, Busy,
    input gnt, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX among NUM_REQ requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int START_TIMEOUT = 4
)(
  input  logic clk,
  input  logic reset,
  uart_tx_arbiter_if.master bus,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic arb_busy,
  output logic timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last, last_nx, win, idx, owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_REQ-1:0] gnt_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic par_en_nx, par_typ_nx, dv_nx, to_nx;
  // descending scan so the requester nearest after last wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_REQ);
      win = bus.req[idx] ? idx : win;
    end
  end
  always_comb begin
    state_nx = state;
    last_nx = last;
    cnt_nx = cnt;
    gnt_nx = '0;
    dv_nx = 1'b0;
    to_nx = 1'b0;
    data_nx = bus.P_DATA;
    par_en_nx = bus.PAR_EN;
    par_typ_nx = bus.PAR_TYP;
    owner_nx = owner;
    case (state)
      IDLE: if (|bus.req && !bus.Busy) begin
        state_nx = LAUNCH;
        data_nx = bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
        par_en_nx = bus.req_par_en[win];
        par_typ_nx = bus.req_par_typ[win];
        dv_nx = 1'b1;
        gnt_nx = NUM_REQ'(1) << win;
        owner_nx = win;
        last_nx = win;
      end
      LAUNCH: begin
        state_nx = WAIT_START;
        cnt_nx = '0;
      end
      WAIT_START: if (bus.Busy) state_nx = WAIT_DONE;
        else if (cnt == CW'(START_TIMEOUT-1)) begin
          state_nx = IDLE;
          to_nx = 1'b1;
        end else cnt_nx = cnt + CW'(1);
      WAIT_DONE: state_nx = bus.Busy ? WAIT_DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last <= IW'(NUM_REQ-1);
      cnt <= '0;
      bus.gnt <= '0;
      bus.P_DATA <= '0;
      bus.PAR_EN <= 1'b0;
      bus.PAR_TYP <= 1'b0;
      bus.DATA_VALID <= 1'b0;
      owner <= '0;
      arb_busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      cnt <= cnt_nx;
      bus.gnt <= gnt_nx;
      bus.P_DATA <= data_nx;
      bus.PAR_EN <= par_en_nx;
      bus.PAR_TYP <= par_typ_nx;
      bus.DATA_VALID <= dv_nx;
      owner <= owner_nx;
      arb_busy <= state_nx != IDLE;
      timeout_err <= to_nx;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ requesters using round-robin arbitration.
- Presents the winner's byte and parity configuration on the transmitter's P_DATA/PAR_EN/PAR_TYP inputs with a one-cycle DATA_VALID pulse.
- Tracks the transmitter's Busy output so that a new frame is never launched while a frame is in flight.
- Sits between the system-side requesters and the UART TX core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of P_DATA.
- START_TIMEOUT, 4, cycles to wait for Busy to rise after a launch before the launch is declared lost (>=2).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held high until its gnt bit pulses.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte in bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req[i]=1.
- req_par_en  in  NUM_REQ  per-requester parity enable.
- req_par_typ  in  NUM_REQ  per-requester parity type (0 even, 1 odd).
- gnt  out  NUM_REQ  one-hot, one-cycle acknowledge; high in the same cycle as DATA_VALID.
- P_DATA  out  DATA_WIDTH  byte to the UART TX.
- PAR_EN  out  1  parity enable to the UART TX.
- PAR_TYP  out  1  parity type to the UART TX.
- DATA_VALID  out  1  one-cycle launch strobe to the UART TX.
- Busy  in  1  UART TX busy flag.
- owner  out  $clog2(NUM_REQ)  index of the last granted requester.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when Busy fails to rise within START_TIMEOUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gnt, P_DATA, PAR_EN, PAR_TYP, DATA_VALID, owner, arb_busy and timeout_err all 0.
  - Round-robin pointer last=NUM_REQ-1, so req[0] has first priority after reset.
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE. All outputs are registered.
- IDLE:
  - Condition: (|req) && Busy==0.
  - Winner w = first set bit of req searching last+1, last+2, ... with modulo NUM_REQ wrap.
  - At that edge: state<=LAUNCH; P_DATA/PAR_EN/PAR_TYP<=winner's values; DATA_VALID<=1; gnt[w]<=1; owner<=w; last<=w.
  - If Busy==1 or req==0: stay in IDLE and launch nothing.
- LAUNCH (lasts exactly one cycle): DATA_VALID<=0; gnt<=0; cnt<=0; state<=WAIT_START.
- WAIT_START:
  - Busy==1: state<=WAIT_DONE.
  - Otherwise cnt<=cnt+1.
  - When cnt==START_TIMEOUT-1 and Busy==0: state<=IDLE and timeout_err<=1 for one cycle. The grant is consumed; there is no retry.
- WAIT_DONE: Busy==0 -> state<=IDLE. The earliest next launch is the cycle after IDLE is re-entered.
- Latency: req sampled at edge k -> DATA_VALID and gnt high in cycle k..k+1. Minimum spacing between launches is therefore frame length + 3 cycles.
- P_DATA, PAR_EN and PAR_TYP hold their last launched values until the next launch.
- Requests arriving or dropping outside IDLE are ignored until IDLE. A requester that drops req before its grant loses its slot with no side effects.
- Simultaneous requests: exactly one gnt bit per launch. Each of the k contending requesters is served within k launches.
- Reset asserted mid-frame: immediate return to reset values and no pulse leaks out. The UART TX core is reset by the same signal.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5, PAR_EN=1, PAR_TYP=1; Busy model rises 1 cycle after DATA_VALID and falls 11 cycles later -> one DATA_VALID pulse, gnt=4'b0100 in the same cycle, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1, owner=2, arb_busy=0 after Busy falls.
- All four requesting, each dropping req after its gnt -> grant order 0,1,2,3 with bytes 8'h10, 8'h21, 8'h32, 8'h43 appearing in that order on P_DATA.
- req0 and req3 held high continuously for 6 launches -> grants alternate 0,3,0,3,0,3.
- Busy tied to 0 after a launch -> timeout_err pulses exactly START_TIMEOUT+1 cycles after DATA_VALID, state returns to IDLE, and the next request is launched.
- Busy held high from the system side while req=4'b0001 -> no DATA_VALID. Busy falls -> DATA_VALID one cycle later.
- reset driven low during WAIT_DONE -> all outputs 0 immediately. After release, req=4'b1000 is granted first ahead of a simultaneous req[1]? No: with pointer at 3, req[1] wins over req[3] (search starts at 0), so drive req=4'b1010 and require gnt=4'b0010.
